// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Includes the RUN/TRAP state type, the trap cause codes and the default trap vector.
package pc_seq_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_e;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_EXT   = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN = 2'd2;

    localparam logic [31:0] EXC_VEC_DFLT = 32'h0000_0080;

endpackage

// File: rtl/pc_src_mux.sv
// NUM_SRC:1 next-PC candidate selector over a flattened input bus.
// A selector value with no matching slot falls back to slot 0.
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_in,
    output logic [WIDTH-1:0]         out
);

    always_comb begin
        out = src_in[0 +: WIDTH];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                out = src_in[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, picks the next PC, applies beq/bne write enables,
// and takes precise traps for external requests and misaligned targets.
//
// state | meaning
// RUN   | normal operation; trap requests, ERET and PC writes are evaluated
// TRAP  | one-cycle trap pulse; pc sits at EXC_VEC and all requests are ignored
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NUM_SRC   = 4,
    parameter int               SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DFLT),
    parameter int               ALIGN     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         PCSource,
    input  logic [NUM_SRC*WIDTH-1:0] src_in,
    input  logic                     PCWrite,
    input  logic                     PCWriteCond,
    input  logic                     BranchNe,
    input  logic                     Zero,
    input  logic                     ExcReq,
    input  logic                     Eret,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         epc,
    output logic [WIDTH-1:0]         badaddr,
    output logic [1:0]               cause,
    output logic                     trap,
    output logic [7:0]               trap_cnt
);

    // Mask form avoids a zero-width slice when the alignment check is disabled.
    localparam logic [WIDTH-1:0] ALIGN_MASK =
        (ALIGN == 0) ? '0 : ((WIDTH'(1) << ALIGN) - WIDTH'(1));

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] badaddr_q, badaddr_d;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       trap_cnt_q, trap_cnt_d;

    logic [WIDTH-1:0] next_pc;
    logic             take;
    logic             mis;
    logic [7:0]       trap_cnt_inc;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .sel    (PCSource),
        .src_in (src_in),
        .out    (next_pc)
    );

    assign take         = PCWrite | (PCWriteCond & (Zero ^ BranchNe));
    assign mis          = take & ((next_pc & ALIGN_MASK) != '0);
    assign trap_cnt_inc = (trap_cnt_q == 8'hFF) ? trap_cnt_q : trap_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        badaddr_d  = badaddr_q;
        cause_d    = cause_q;
        trap_cnt_d = trap_cnt_q;
        case (state_q)
            RUN: begin
                if (ExcReq) begin
                    epc_d      = pc_q;
                    cause_d    = CAUSE_EXT;
                    pc_d       = EXC_VEC;
                    trap_cnt_d = trap_cnt_inc;
                    state_d    = TRAP;
                end else if (Eret) begin
                    pc_d    = epc_q;
                    cause_d = CAUSE_NONE;
                end else if (mis) begin
                    epc_d      = pc_q;
                    badaddr_d  = next_pc;
                    cause_d    = CAUSE_ALIGN;
                    pc_d       = EXC_VEC;
                    trap_cnt_d = trap_cnt_inc;
                    state_d    = TRAP;
                end else if (take) begin
                    pc_d = next_pc;
                end
            end
            TRAP: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            badaddr_q  <= '0;
            cause_q    <= CAUSE_NONE;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            badaddr_q  <= badaddr_d;
            cause_q    <= cause_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign badaddr  = badaddr_q;
    assign cause    = cause_q;
    assign trap     = (state_q == TRAP);
    assign trap_cnt = trap_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model pushes the expected register
// image for every driven cycle, which is popped and compared after the clock edge.
module tb_pc_sequencer;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] badaddr;
        logic [1:0]  cause;
        logic        trap;
        logic [7:0]  trap_cnt;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [SEL_W-1:0]         PCSource = '0;
    logic [NUM_SRC*WIDTH-1:0] src_in;
    logic                     PCWrite = 1'b0;
    logic                     PCWriteCond = 1'b0;
    logic                     BranchNe = 1'b0;
    logic                     Zero = 1'b0;
    logic                     ExcReq = 1'b0;
    logic                     Eret = 1'b0;
    logic [WIDTH-1:0]         pc, epc, badaddr;
    logic [1:0]               cause;
    logic                     trap;
    logic [7:0]               trap_cnt;

    logic [31:0] slot [NUM_SRC];
    exp_t        sb_q [$];
    exp_t        m;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .NUM_SRC   (NUM_SRC),
        .SEL_W     (SEL_W),
        .RESET_VEC (32'h0),
        .EXC_VEC   (32'h80),
        .ALIGN     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSource    (PCSource),
        .src_in      (src_in),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchNe    (BranchNe),
        .Zero        (Zero),
        .ExcReq      (ExcReq),
        .Eret        (Eret),
        .pc          (pc),
        .epc         (epc),
        .badaddr     (badaddr),
        .cause       (cause),
        .trap        (trap),
        .trap_cnt    (trap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: advance m by one clock using the current inputs.
    task automatic model_step();
        logic [31:0] nxt;
        logic        tk;
        logic        in_trap;
        in_trap = m.trap;
        nxt = (PCSource < NUM_SRC) ? slot[PCSource] : slot[0];
        tk  = PCWrite || (PCWriteCond && (Zero != BranchNe));
        m.trap = 1'b0;
        if (reset) begin
            m = '{pc: 32'h0, epc: 32'h0, badaddr: 32'h0, cause: 2'd0, trap: 1'b0, trap_cnt: 8'd0};
        end else if (in_trap) begin
            // trap cycle: nothing but the state changes
        end else if (ExcReq) begin
            m.epc = m.pc; m.cause = 2'd1; m.pc = 32'h80; m.trap = 1'b1;
            if (m.trap_cnt != 8'd255) m.trap_cnt = m.trap_cnt + 8'd1;
        end else if (Eret) begin
            m.pc = m.epc; m.cause = 2'd0;
        end else if (tk && nxt[1:0] != 2'b00) begin
            m.epc = m.pc; m.badaddr = nxt; m.cause = 2'd2; m.pc = 32'h80; m.trap = 1'b1;
            if (m.trap_cnt != 8'd255) m.trap_cnt = m.trap_cnt + 8'd1;
        end else if (tk) begin
            m.pc = nxt;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("pc",       pc,       e.pc);
        chk("epc",      epc,      e.epc);
        chk("badaddr",  badaddr,  e.badaddr);
        chk("cause",    {30'd0, cause}, {30'd0, e.cause});
        chk("trap",     {31'd0, trap},  {31'd0, e.trap});
        chk("trap_cnt", {24'd0, trap_cnt}, {24'd0, e.trap_cnt});
    endtask

    task automatic idle_inputs();
        PCWrite = 0; PCWriteCond = 0; BranchNe = 0; Zero = 0; ExcReq = 0; Eret = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        slot[0] = 32'h10; slot[1] = 32'h24; slot[2] = 32'h40; slot[3] = 32'h46;
        src_in = {slot[3], slot[2], slot[1], slot[0]};
        m = '{pc: 32'h0, epc: 32'h0, badaddr: 32'h0, cause: 2'd0, trap: 1'b0, trap_cnt: 8'd0};

        reset = 1; tick(); tick();
        reset = 0; tick();
        chk("reset_pc", pc, 32'h0);
        chk("reset_trap", {31'd0, trap}, 32'd0);

        // Unconditional writes, including out-of-range selectors
        PCSource = 3'd2; PCWrite = 1; tick();
        chk("write_slot2", pc, 32'h40);
        PCSource = 3'd5; tick();
        chk("sel5_slot0", pc, 32'h10);
        PCSource = 3'd4; tick();
        PCSource = 3'd1; tick();
        PCSource = 3'd0; tick();

        // Conditional branches
        idle_inputs(); PCWriteCond = 1; PCSource = 3'd2;
        BranchNe = 0; Zero = 0; tick();
        chk("beq_not_taken", pc, 32'h10);
        Zero = 1; tick();
        chk("beq_taken", pc, 32'h40);
        PCSource = 3'd1; BranchNe = 1; Zero = 0; tick();
        chk("bne_taken", pc, 32'h24);
        PCSource = 3'd3; BranchNe = 1; Zero = 1; tick();
        chk("cond_false_no_align", {31'd0, trap}, 32'd0);

        // Misaligned target trap, ignored write during TRAP, then ERET
        idle_inputs(); PCWrite = 1; PCSource = 3'd2; tick();
        PCSource = 3'd3; tick();
        chk("mis_pc", pc, 32'h80);
        chk("mis_badaddr", badaddr, 32'h46);
        chk("mis_cause", {30'd0, cause}, 32'd2);
        PCSource = 3'd0; tick();
        chk("trap_one_cycle", {31'd0, trap}, 32'd0);
        idle_inputs(); Eret = 1; tick();
        chk("eret_pc", pc, 32'h40);
        idle_inputs(); tick();

        // ExcReq beats Eret; ExcReq during TRAP is dropped
        reset = 1; tick(); reset = 0;
        PCWrite = 1; PCSource = 3'd0; tick();
        idle_inputs(); ExcReq = 1; Eret = 1; tick();
        chk("exc_epc", epc, 32'h10);
        chk("exc_cause", {30'd0, cause}, 32'd1);
        Eret = 0; tick();
        idle_inputs(); tick();
        chk("exc_in_trap_dropped", {24'd0, trap_cnt}, 32'd1);

        // Saturating trap counter
        for (int i = 0; i < 300; i++) begin
            ExcReq = 1; tick();
            ExcReq = 0; tick();
        end
        chk("cnt_saturated", {24'd0, trap_cnt}, 32'd255);

        // Reset in the middle of TRAP
        ExcReq = 1; tick();
        ExcReq = 0; reset = 1; tick();
        chk("rst_in_trap_pc", pc, 32'h0);
        chk("rst_in_trap_trap", {31'd0, trap}, 32'd0);
        reset = 0; tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
